// File: rtl/nibble_serial_subtractor_pkg.sv
// nss_pkg: shared slice width, FSM encoding and counter-width helper for the nibble subtractor
package nss_pkg;
  localparam int NIB = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// nibble_sub_slice: 4-bit carry-lookahead add of x, pre-inverted y and carry-in
module nibble_sub_slice (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;
  assign w_g = i_x & i_y;
  assign w_p = i_x ^ i_y;
  // every carry is a flat sum of products of g/p and cin, so no carry ripples through another
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_s    = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: a - b one nibble per clock with start/done handshake and result flags
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / NIB;
  localparam int CW = clog2(N);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_busy, r_done, r_borrow, r_ovf, r_zero;
  logic [NIB-1:0]   w_x, w_y, w_s;
  logic             w_cout, w_last, w_ovf, w_zero;
  assign w_x    = r_a[r_cnt*NIB +: NIB];
  assign w_y    = r_b[r_cnt*NIB +: NIB];
  assign w_last = r_cnt == CW'(N - 1);
  // r_b holds ~b, so the subtrahend sign is the inverse of its stored MSB
  assign w_ovf  = (r_a[WIDTH-1] ^ ~r_b[WIDTH-1]) & (w_s[NIB-1] ^ r_a[WIDTH-1]);
  assign w_zero = ~|r_diff[WIDTH-NIB-1:0] & ~|w_s;
  nibble_sub_slice u_slice (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (r_state == RUN) begin
      r_diff[r_cnt*NIB +: NIB] <= w_s;
      r_carry                  <= w_cout;
      r_cnt                    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_state  <= DONE;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_borrow <= ~w_cout;
        r_ovf    <= w_ovf;
        r_zero   <= w_zero;
      end
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state <= RUN;
        r_a     <= a;
        r_b     <= ~b;
        r_carry <= 1'b1;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else begin
        r_state <= IDLE;
      end
    end
  end
  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;
  assign zero       = r_zero;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed corner cases plus a random sweep against an arithmetic model
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] a, b, diff;
  logic        busy, done, borrow_out, overflow, zero;
  int          n_chk = 0, n_bad = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {borrow, ovf, zero, diff} from plain unsigned and signed arithmetic
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
    int          ux, uy, sd;
    logic [15:0] d;
    ux = int'(x);
    uy = int'(y);
    sd = int'($signed(x)) - int'($signed(y));
    d  = 16'((ux - uy) & 16'hFFFF);
    return {ux < uy, (sd > 32767) || (sd < -32768), d == 16'h0, d};
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic [18:0] exp);
    int lat, bcy;
    lat   = 0;
    bcy   = 0;
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    check("done_after_accept", {31'b0, done}, 0);
    while (!done && lat < 20) begin
      bcy += int'(busy);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    check("busy_cycles", bcy, 4);
    check("busy_at_done", {31'b0, busy}, 0);
    check("diff", {16'b0, diff}, {16'b0, exp[15:0]});
    check("borrow", {31'b0, borrow_out}, {31'b0, exp[18]});
    check("overflow", {31'b0, overflow}, {31'b0, exp[17]});
    check("zero", {31'b0, zero}, {31'b0, exp[16]});
  endtask

  initial begin
    int          lat, pulses;
    logic        prev;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_outputs", {11'b0, busy, done, borrow_out, overflow, zero, diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(16'h1234, 16'h0234, {3'b000, 16'h1000});
    do_op(16'h0000, 16'h0001, {3'b100, 16'hFFFF});
    do_op(16'h8000, 16'h0001, {3'b010, 16'h7FFF});
    do_op(16'h7FFF, 16'hFFFF, {3'b110, 16'h8000});
    do_op(16'hABCD, 16'hABCD, {3'b001, 16'h0000});
    @(posedge clk);
    #1;
    check("idle_after_done", {30'b0, busy, done}, 0);
    a     = 16'h1234;
    b     = 16'h0234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 2;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignored_start_latency", lat, 4);
    check("ignored_start_diff", {16'b0, diff}, 32'h1000);
    a      = 16'h0005;
    b      = 16'h0003;
    start  = 1'b1;
    prev   = done;
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("no_double_done", {31'b0, prev & done}, 0);
      pulses += int'(done);
      prev = done;
    end
    start = 1'b0;
    check("b2b_pulses", pulses, 1);
    check("b2b_done_at_4", {31'b0, done}, 1);
    check("b2b_diff", {16'b0, diff}, 32'h0002);
    @(posedge clk);
    #1;
    check("b2b_idle", {30'b0, busy, done}, 0);
    a     = 16'h0123;
    b     = 16'h0456;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {11'b0, busy, done, borrow_out, overflow, zero, diff}, 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      pulses += int'(done);
    end
    check("abort_no_done", pulses, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(16'h0010, 16'h0001, {3'b000, 16'h000F});
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = (i % 16 == 0) ? ra : 16'($urandom);
      do_op(ra, rb, model(ra, rb));
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
